decode_ctrl_stage: RTL and testbench
====================================

# decode_ctrl_stage

Decode-stage control unit with integrated ID/EX control pipeline register and a multi-cycle MDU sequencer. It decodes opcode/funct3/funct7 of the instruction in D. Its main outputs are:
- combinational `immSrcD` for the D-stage immediate extender;
- a registered E-stage control bundle with stall/flush.

When `M_EXT=1` it decodes RV32M and sequences the multi-cycle divider, stalling the pipe until the divider completes.

## Interface
- `M_EXT`, default 1: 1 = decode RV32M; 0 = RV32M encodings flagged illegal.
- `FENCE_NOP`, default 1: 1 = FENCE/FENCE.I decode as valid no-op; 0 = illegal.
- Clock and reset: one clock; reset is asynchronous and active-low.
- `clk`  in  1  rising-edge clock.
- `rst_n`  in  1  async active-low reset.
- `instrD`  in  32  instruction in D.
- `validD`  in  1  `instrD` is a real instruction (not a bubble).
- `stallE`  in  1  hazard unit: hold E register.
- `flushE`  in  1  hazard unit: load bubble into E.
- `mdu_done`  in  1  divider result valid (single-cycle pulse).
- `immSrcD`  out  3  I=000 S=001 B=010 U=011 J=100 (combinational).
- `validE, regWriteE, memWriteE, jumpE, branchE, aluSrcE`  out  1 each  registered controls.
- `aluOpE`  out  2  00 add, 01 branch compare, 10 funct-decoded.
- `resultSrcE`  out  3  000 ALU, 001 mem, 010 PC+4, 011 imm, 100 MDU.
- `funct3E`  out  3  registered funct3.
- `mduE`  out  1  E holds an M-extension op.
- `illegalE`  out  1  E holds an undecodable instruction.
- `mdu_start`  out  1  one-cycle divider launch.
- `mdu_kill`  out  1  one-cycle abort of an in-flight divide.
- `stall_mdu`  out  1  request to stall F/D/E.

## Operation
- Decode by opcode:
  - R: RF write, aluOp 10.
  - OP-IMM: RF write, aluSrc, aluOp 10, imm I.
  - LOAD: RF write, aluSrc, result mem, imm I.
  - STORE: mem write, aluSrc, imm S.
  - BRANCH: branch, aluOp 01, imm B.
  - JALR: RF write, jump, aluSrc, result PC+4, imm I.
  - JAL: RF write, jump, result PC+4, imm J.
  - LUI: RF write, result imm, imm U.
  - AUIPC: RF write, aluSrc, imm U.
- Undecoded fields default to 0.
- RV32M (R opcode, funct7=0000001):
  - With `M_EXT=1`: `mdu`=1, result 100, aluOp 00.
  - With `M_EXT=0`: illegal.
- Divide class is `mduE & funct3E[2]` (DIV/DIVU/REM/REMU). MUL class (`funct3E[2]`=0) is single-cycle and bypasses the sequencer.
- Illegal conditions:
  - unknown opcode;
  - R-type funct7 not in {0000000, 0100000, 0000001 when M_EXT};
  - FENCE with `FENCE_NOP=0`;
  - SYSTEM.
- Illegal instructions load into E with `illegalE=1`, `validE=1`, and all write/branch/jump controls 0.
- E register update priority: `flushE` > (`stallE | stall_mdu`) > load. Bubble = all outputs 0, including `validE`. `validD=0` loads a bubble.
- MDU sequencer FSM, states IDLE and BUSY, plus a `served` flag:
  - IDLE, when `validE & divE & !served`: assert `mdu_start`, go BUSY.
  - BUSY: if `mdu_done`, set `served`, go IDLE.
  - `served` clears whenever the E register loads or flushes.
- `stall_mdu` = (IDLE & launch condition) | (BUSY & !`mdu_done`).
- `flushE` in BUSY: `mdu_kill` pulse, go IDLE, clear `served`. `mdu_done` in the same cycle is ignored.
- `flushE` in the launch cycle: suppress `mdu_start`.

## Timing
- `immSrcD`: zero-latency combinational from `instrD`.
- E controls: one-cycle latency, D to E on the rising edge.
- Divide sequencing:
  - `mdu_start` is asserted in the first cycle the divide sits in E.
  - `stall_mdu` is high from that cycle through the cycle before `mdu_done`.
  - E advances on the `mdu_done` cycle unless `stallE` is also high.
- `stallE` high on the `mdu_done` cycle: E holds, `served`=1, so there is no relaunch.
- Back-to-back divides: the second launches in its first E cycle.
- Reset (async assert, any state including BUSY): all outputs 0, FSM IDLE, `served`=0. No `mdu_kill` is issued on reset, because the divider has its own reset.

## Structure
- Package `ctrl_pkg` holds:
  - opcode localparams;
  - `imm_src_e` (3 b), `result_src_e` (3 b), `alu_op_e` (2 b);
  - packed struct `ctrl_bundle_t` containing the E-stage controls.
- Sub-module `main_decoder`, purely combinational: `instrD` to `ctrl_bundle_t` plus `immSrc`, parametrised by `M_EXT` and `FENCE_NOP`.
- The top module holds the E register and the MDU FSM.

## Test plan
- Directed decode, one instruction per opcode:
  - `0x00A30293` (addi) → next cycle `regWriteE`=1, `aluSrcE`=1, `aluOpE`=10, `resultSrcE`=000.
  - SW → `immSrcD`=001.
  - JAL → `immSrcD`=100, `resultSrcE`=010.
- `0x02C5C533` (div) with `mdu_done` 4 cycles after `mdu_start`:
  - single-cycle `mdu_start`;
  - `stall_mdu`=1 for exactly 4 cycles;
  - E advances on the done cycle.
- `M_EXT=0`, mul `0x02C58533` → `illegalE`=1, `regWriteE`=0.
- `stallE` held across `mdu_done` → exactly one `mdu_start`, E holds, no relaunch.
- `flushE` in BUSY → `mdu_kill` pulse, `validE`=0, FSM IDLE; a later `mdu_done` is ignored.
- `rst_n` low mid-BUSY → all outputs 0 immediately (async); after release, the next divide launches normally.

Source files
------------

// File: rtl/ctrl_pkg.sv
// Shared types and constants for the decode-stage control unit: base and
// M-extension opcodes, control-field encodings and the E-stage control bundle.
package ctrl_pkg;

  // Major opcodes (instr[6:0]) of the RV32I base set.
  localparam logic [6:0] OP_LOAD     = 7'b0000011;
  localparam logic [6:0] OP_MISC_MEM = 7'b0001111;
  localparam logic [6:0] OP_IMM      = 7'b0010011;
  localparam logic [6:0] OP_AUIPC    = 7'b0010111;
  localparam logic [6:0] OP_STORE    = 7'b0100011;
  localparam logic [6:0] OP_REG      = 7'b0110011;
  localparam logic [6:0] OP_LUI      = 7'b0110111;
  localparam logic [6:0] OP_BRANCH   = 7'b1100011;
  localparam logic [6:0] OP_JALR     = 7'b1100111;
  localparam logic [6:0] OP_JAL      = 7'b1101111;
  localparam logic [6:0] OP_SYSTEM   = 7'b1110011;

  // funct7 values accepted on the register-register opcode.
  localparam logic [6:0] F7_BASE   = 7'b0000000;
  localparam logic [6:0] F7_ALT    = 7'b0100000;
  localparam logic [6:0] F7_MULDIV = 7'b0000001;

  // Immediate format selected for the D-stage extender.
  typedef enum logic [2:0] {
    IMM_I = 3'b000,
    IMM_S = 3'b001,
    IMM_B = 3'b010,
    IMM_U = 3'b011,
    IMM_J = 3'b100
  } imm_src_e;

  // Source of the value written back to the register file.
  typedef enum logic [2:0] {
    RES_ALU = 3'b000,
    RES_MEM = 3'b001,
    RES_PC4 = 3'b010,
    RES_IMM = 3'b011,
    RES_MDU = 3'b100
  } result_src_e;

  // ALU operation class handed to the E-stage ALU decoder.
  typedef enum logic [1:0] {
    ALU_ADD    = 2'b00,
    ALU_BRANCH = 2'b01,
    ALU_FUNCT  = 2'b10
  } alu_op_e;

  // Control bundle carried from D into E.
  typedef struct packed {
    logic        valid;
    logic        regWrite;
    logic        memWrite;
    logic        jump;
    logic        branch;
    logic        aluSrc;
    alu_op_e     aluOp;
    result_src_e resultSrc;
    logic [2:0]  funct3;
    logic        mdu;
    logic        illegal;
  } ctrl_bundle_t;

  // An undecodable instruction still occupies E (so a trap can be raised
  // later) but must never write state, branch or jump.
  function automatic ctrl_bundle_t illegalBundle(input logic [2:0] funct3);
    ctrl_bundle_t c;
    c         = '0;
    c.valid   = 1'b1;
    c.funct3  = funct3;
    c.illegal = 1'b1;
    return c;
  endfunction

  // DIV/DIVU/REM/REMU have funct3[2] set; MUL* are single-cycle.
  function automatic logic isDivide(input ctrl_bundle_t c);
    return c.mdu & c.funct3[2];
  endfunction

endpackage

// File: rtl/main_decoder.sv
// Purely combinational main decoder: turns the D-stage instruction into the
// E-stage control bundle and the immediate format for the D-stage extender.
module main_decoder
  import ctrl_pkg::*;
#(
  parameter bit M_EXT     = 1'b1,
  parameter bit FENCE_NOP = 1'b1
) (
  input  logic [31:0]  instrD,
  output ctrl_bundle_t ctrlD,
  output imm_src_e     immSrc
);

  logic [6:0] opcode;
  logic [2:0] funct3;
  logic [6:0] funct7;
  logic       isIllegal;
  logic       unusedFields;

  assign opcode = instrD[6:0];
  assign funct3 = instrD[14:12];
  assign funct7 = instrD[31:25];

  // Register specifiers and immediate bits are consumed elsewhere in D.
  assign unusedFields = ^{instrD[24:15], instrD[11:7]};

  // Opcode-driven decode; every control not named for an opcode stays 0.
  always_comb begin
    // NOTE: every output gets a default before the case so no path leaves a
    // signal unassigned, which would otherwise infer a latch.
    ctrlD        = '0;
    ctrlD.valid  = 1'b1;
    ctrlD.funct3 = funct3;
    immSrc       = IMM_I;
    isIllegal    = 1'b0;

    case (opcode)
      OP_REG: begin
        ctrlD.regWrite = 1'b1;
        ctrlD.aluOp    = ALU_FUNCT;
        if (M_EXT && funct7 == F7_MULDIV) begin
          ctrlD.mdu       = 1'b1;
          ctrlD.resultSrc = RES_MDU;
          ctrlD.aluOp     = ALU_ADD;
        end else if (funct7 != F7_BASE && funct7 != F7_ALT) begin
          isIllegal = 1'b1;
        end
      end
      OP_IMM: begin
        ctrlD.regWrite = 1'b1;
        ctrlD.aluSrc   = 1'b1;
        ctrlD.aluOp    = ALU_FUNCT;
        immSrc         = IMM_I;
      end
      OP_LOAD: begin
        ctrlD.regWrite  = 1'b1;
        ctrlD.aluSrc    = 1'b1;
        ctrlD.resultSrc = RES_MEM;
        immSrc          = IMM_I;
      end
      OP_STORE: begin
        ctrlD.memWrite = 1'b1;
        ctrlD.aluSrc   = 1'b1;
        immSrc         = IMM_S;
      end
      OP_BRANCH: begin
        ctrlD.branch = 1'b1;
        ctrlD.aluOp  = ALU_BRANCH;
        immSrc       = IMM_B;
      end
      OP_JALR: begin
        ctrlD.regWrite  = 1'b1;
        ctrlD.jump      = 1'b1;
        ctrlD.aluSrc    = 1'b1;
        ctrlD.resultSrc = RES_PC4;
        immSrc          = IMM_I;
      end
      OP_JAL: begin
        ctrlD.regWrite  = 1'b1;
        ctrlD.jump      = 1'b1;
        ctrlD.resultSrc = RES_PC4;
        immSrc          = IMM_J;
      end
      OP_LUI: begin
        ctrlD.regWrite  = 1'b1;
        ctrlD.resultSrc = RES_IMM;
        immSrc          = IMM_U;
      end
      OP_AUIPC: begin
        ctrlD.regWrite = 1'b1;
        ctrlD.aluSrc   = 1'b1;
        immSrc         = IMM_U;
      end
      OP_MISC_MEM: begin
        // In-order single-hart pipe: FENCE/FENCE.I need no action.
        if (!FENCE_NOP) isIllegal = 1'b1;
      end
      OP_SYSTEM: isIllegal = 1'b1;
      default:   isIllegal = 1'b1;
    endcase

    if (isIllegal) begin
      ctrlD  = illegalBundle(funct3);
      immSrc = IMM_I;
    end
  end

endmodule

// File: rtl/decode_ctrl_stage.sv
// Decode-stage control: main decoder, ID/EX control register with
// flush/stall, and the sequencer that launches and waits on the divider.
module decode_ctrl_stage
  import ctrl_pkg::*;
#(
  parameter bit M_EXT     = 1'b1,
  parameter bit FENCE_NOP = 1'b1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] instrD,
  input  logic        validD,
  input  logic        stallE,
  input  logic        flushE,
  input  logic        mdu_done,
  output logic [2:0]  immSrcD,
  output logic        validE,
  output logic        regWriteE,
  output logic        memWriteE,
  output logic        jumpE,
  output logic        branchE,
  output logic        aluSrcE,
  output logic [1:0]  aluOpE,
  output logic [2:0]  resultSrcE,
  output logic [2:0]  funct3E,
  output logic        mduE,
  output logic        illegalE,
  output logic        mdu_start,
  output logic        mdu_kill,
  output logic        stall_mdu
);

  typedef enum logic {
    MDU_IDLE = 1'b0,
    MDU_BUSY = 1'b1
  } mdu_state_e;

  ctrl_bundle_t ctrlD;
  ctrl_bundle_t ctrlE;
  imm_src_e     immSrc;
  mdu_state_e   mduState;
  logic         served;
  logic         launchReq;
  logic         inIdle;
  logic         inBusy;
  logic         holdE;
  logic         loadE;

  main_decoder #(
    .M_EXT    (M_EXT),
    .FENCE_NOP(FENCE_NOP)
  ) uMainDecoder (
    .instrD(instrD),
    .ctrlD (ctrlD),
    .immSrc(immSrc)
  );

  assign immSrcD = immSrc;

  // A divide in E needs the divider once; 'served' remembers it already
  // completed while E was held, so it is not launched a second time.
  assign launchReq = ctrlE.valid & isDivide(ctrlE) & ~served;
  assign inIdle    = (mduState == MDU_IDLE);
  assign inBusy    = (mduState == MDU_BUSY);

  // Divider handshake is decided in the same cycle the divide sits in E and
  // reacts to flushE in that cycle, so these are combinational.
  assign stall_mdu = (inIdle & launchReq) | (inBusy & ~mdu_done);
  assign mdu_start = inIdle & launchReq & ~flushE;
  assign mdu_kill  = inBusy & flushE;

  assign holdE = stallE | stall_mdu;
  assign loadE = ~flushE & ~holdE;

  // ID/EX control register: flush beats stall beats load; an invalid D slot
  // loads as a bubble.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of block ordering.
    if (!rst_n) begin
      ctrlE <= '0;
    end else if (flushE) begin
      ctrlE <= '0;
    end else if (!holdE) begin
      if (validD) ctrlE <= ctrlD;
      else        ctrlE <= '0;
    end
  end

  // Divider sequencer: IDLE launches, BUSY waits for done or is aborted by a
  // flush; 'served' clears whenever E takes a new occupant.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mduState <= MDU_IDLE;
      served   <= 1'b0;
    end else begin
      if (inIdle) begin
        if (launchReq && !flushE) mduState <= MDU_BUSY;
      end else begin
        if (flushE || mdu_done) mduState <= MDU_IDLE;
      end

      if (flushE || loadE) begin
        served <= 1'b0;
      end else if (inBusy && mdu_done) begin
        served <= 1'b1;
      end
    end
  end

  assign validE     = ctrlE.valid;
  assign regWriteE  = ctrlE.regWrite;
  assign memWriteE  = ctrlE.memWrite;
  assign jumpE      = ctrlE.jump;
  assign branchE    = ctrlE.branch;
  assign aluSrcE    = ctrlE.aluSrc;
  assign aluOpE     = ctrlE.aluOp;
  assign resultSrcE = ctrlE.resultSrc;
  assign funct3E    = ctrlE.funct3;
  assign mduE       = ctrlE.mdu;
  assign illegalE   = ctrlE.illegal;

endmodule

// File: tb/tb_decode_ctrl_stage.sv
// Scoreboard bench for decode_ctrl_stage: stimulus pushes the expected E
// bundle when D is accepted; a monitor compares whatever occupies E.
module tb_decode_ctrl_stage;

  localparam int DIV_LAT = 4;

  localparam logic [31:0] I_ADDI  = 32'h00A30293;
  localparam logic [31:0] I_SW    = 32'h00532423;
  localparam logic [31:0] I_BEQ   = 32'h00628863;
  localparam logic [31:0] I_JAL   = 32'h000000EF;
  localparam logic [31:0] I_JALR  = 32'h00008067;
  localparam logic [31:0] I_LW    = 32'h00432283;
  localparam logic [31:0] I_LUI   = 32'h123402B7;
  localparam logic [31:0] I_AUIPC = 32'h00000297;
  localparam logic [31:0] I_ADD   = 32'h00C58533;
  localparam logic [31:0] I_SUB   = 32'h40C58533;
  localparam logic [31:0] I_BADF7 = 32'h08C58533;
  localparam logic [31:0] I_ECALL = 32'h00000073;
  localparam logic [31:0] I_FENCE = 32'h0FF0000F;
  localparam logic [31:0] I_UNK   = 32'h0000007F;
  localparam logic [31:0] I_MUL   = 32'h02C58533;
  localparam logic [31:0] I_DIV   = 32'h02C5C533;
  localparam logic [31:0] I_REM   = 32'h02C5E533;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] instrD = '0;
  logic        validD = 1'b0;
  logic        stallE = 1'b0;
  logic        flushE = 1'b0;
  logic        mdu_done = 1'b0;

  logic [2:0] immSrcD, aluOpE2, resultSrcE, funct3E, immSrcD2, resultSrcE2, funct3E2;
  logic [1:0] aluOpE;
  logic validE, regWriteE, memWriteE, jumpE, branchE, aluSrcE, mduE, illegalE;
  logic mdu_start, mdu_kill, stall_mdu;
  logic validE2, regWriteE2, memWriteE2, jumpE2, branchE2, aluSrcE2, mduE2, illegalE2;
  logic mdu_start2, mdu_kill2, stall_mdu2;

  decode_ctrl_stage dut (
    .clk(clk), .rst_n(rst_n), .instrD(instrD), .validD(validD),
    .stallE(stallE), .flushE(flushE), .mdu_done(mdu_done),
    .immSrcD(immSrcD), .validE(validE), .regWriteE(regWriteE),
    .memWriteE(memWriteE), .jumpE(jumpE), .branchE(branchE),
    .aluSrcE(aluSrcE), .aluOpE(aluOpE), .resultSrcE(resultSrcE),
    .funct3E(funct3E), .mduE(mduE), .illegalE(illegalE),
    .mdu_start(mdu_start), .mdu_kill(mdu_kill), .stall_mdu(stall_mdu)
  );

  decode_ctrl_stage #(.M_EXT(1'b0)) dutNoM (
    .clk(clk), .rst_n(rst_n), .instrD(instrD), .validD(validD),
    .stallE(stallE), .flushE(flushE), .mdu_done(mdu_done),
    .immSrcD(immSrcD2), .validE(validE2), .regWriteE(regWriteE2),
    .memWriteE(memWriteE2), .jumpE(jumpE2), .branchE(branchE2),
    .aluSrcE(aluSrcE2), .aluOpE(aluOpE2[1:0]), .resultSrcE(resultSrcE2),
    .funct3E(funct3E2), .mduE(mduE2), .illegalE(illegalE2),
    .mdu_start(mdu_start2), .mdu_kill(mdu_kill2), .stall_mdu(stall_mdu2)
  );
  assign aluOpE2[2] = 1'b0;

  always #5 clk = ~clk;

  int nTests = 0;
  int nFail = 0;
  int startCnt = 0;
  int stallCnt = 0;
  int killCnt = 0;
  int divRem = 0;
  logic prevStart = 1'b0;
  time startT = 0;
  logic [15:0] expQ[$];

  wire [15:0] eBus = {validE, regWriteE, memWriteE, jumpE, branchE, aluSrcE,
                      aluOpE, resultSrcE, funct3E, mduE, illegalE};
  wire [15:0] eBus2 = {validE2, regWriteE2, memWriteE2, jumpE2, branchE2, aluSrcE2,
                       aluOpE2[1:0], resultSrcE2, funct3E2, mduE2, illegalE2};

  function automatic logic [15:0] mk(input logic rw, input logic mw, input logic j,
                                     input logic b, input logic as, input logic [1:0] op,
                                     input logic [2:0] res, input logic [2:0] f3,
                                     input logic mdu);
    return {1'b1, rw, mw, j, b, as, op, res, f3, mdu, 1'b0};
  endfunction

  function automatic logic [15:0] mkIll(input logic [2:0] f3);
    return {1'b1, 5'b0, 2'b00, 3'b000, f3, 1'b0, 1'b1};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    nTests++;
    if (act !== req) begin
      nFail++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, req, $time);
    end
  endtask

  // Monitor: compare E against the scoreboard head; pop when E moves on.
  always @(negedge clk) begin
    if (rst_n && validE) begin
      if (expQ.size() == 0) begin
        check("E occupied with nothing expected", {16'h0, eBus}, 32'h0);
      end else begin
        check("E bundle", {16'h0, eBus}, {16'h0, expQ[0]});
        if (flushE || !(stallE || stall_mdu)) void'(expQ.pop_front());
      end
    end
    if (mdu_start) begin
      startCnt++;
      startT = $time;
      if (prevStart) check("mdu_start single-cycle", 32'd2, 32'd1);
    end
    if (stall_mdu) stallCnt++;
    if (mdu_kill) killCnt++;
    prevStart = mdu_start;
  end

  // Divider model: done pulses DIV_LAT cycles after start; a kill does not
  // abort it, so a stale done reaches the DUT after a flush.
  initial begin
    logic startNow;
    forever begin
      @(negedge clk);
      startNow = mdu_start;
      @(posedge clk);
      #1;
      mdu_done = 1'b0;
      if (!rst_n) begin
        divRem = 0;
      end else if (startNow) begin
        divRem = DIV_LAT - 1;
      end else if (divRem > 0) begin
        divRem--;
        if (divRem == 0) mdu_done = 1'b1;
      end
    end
  end

  task automatic send(input logic [31:0] ins, input logic [15:0] expE,
                      input logic [2:0] expImm, input string name, output time accT);
    bit accepted;
    accepted = 1'b0;
    accT = 0;
    instrD = ins;
    validD = 1'b1;
    for (int i = 0; i < 40 && !accepted; i++) begin
      @(negedge clk);
      if (i == 0) check({name, " immSrcD"}, {29'h0, immSrcD}, {29'h0, expImm});
      if (!flushE && !stallE && !stall_mdu) begin
        accT = $time;
        accepted = 1'b1;
      end
      @(posedge clk);
      if (accepted) expQ.push_back(expE);
    end
    if (!accepted) check({name, " accept timeout"}, 32'd0, 32'd1);
    #1;
    validD = 1'b0;
    instrD = '0;
  endtask

  task automatic idle(input int n);
    validD = 1'b0;
    instrD = '0;
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    time accT;
    int s0, st0, k0;

    // Reset state.
    #12;
    check("reset outputs", {10'h0, immSrcD, eBus, mdu_start, mdu_kill, stall_mdu}, 32'h0);
    check("reset outputs noM", {10'h0, immSrcD2, eBus2, mdu_start2, mdu_kill2, stall_mdu2}, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Directed decode, one per opcode class.
    send(I_ADDI,  mk(1,0,0,0,1,2'b10,3'b000,3'b000,0), 3'b000, "addi", accT);
    send(I_SW,    mk(0,1,0,0,1,2'b00,3'b000,3'b010,0), 3'b001, "sw", accT);
    send(I_BEQ,   mk(0,0,0,1,0,2'b01,3'b000,3'b000,0), 3'b010, "beq", accT);
    send(I_JAL,   mk(1,0,1,0,0,2'b00,3'b010,3'b000,0), 3'b100, "jal", accT);
    send(I_JALR,  mk(1,0,1,0,1,2'b00,3'b010,3'b000,0), 3'b000, "jalr", accT);
    send(I_LW,    mk(1,0,0,0,1,2'b00,3'b001,3'b010,0), 3'b000, "lw", accT);
    send(I_LUI,   mk(1,0,0,0,0,2'b00,3'b011,3'b000,0), 3'b011, "lui", accT);
    send(I_AUIPC, mk(1,0,0,0,1,2'b00,3'b000,3'b000,0), 3'b011, "auipc", accT);
    send(I_ADD,   mk(1,0,0,0,0,2'b10,3'b000,3'b000,0), 3'b000, "add", accT);
    send(I_SUB,   mk(1,0,0,0,0,2'b10,3'b000,3'b000,0), 3'b000, "sub", accT);
    send(I_BADF7, mkIll(3'b000), 3'b000, "bad funct7", accT);
    send(I_ECALL, mkIll(3'b000), 3'b000, "ecall", accT);
    send(I_FENCE, mk(0,0,0,0,0,2'b00,3'b000,3'b000,0), 3'b000, "fence", accT);
    send(I_UNK,   mkIll(3'b000), 3'b000, "unknown opcode", accT);
    idle(1);
    @(negedge clk);
    check("bubble after validD=0", {31'h0, validE}, 32'd0);
    @(posedge clk);
    #1;

    // MUL: single-cycle with M_EXT=1, illegal with M_EXT=0.
    st0 = startCnt;
    send(I_MUL, mk(1,0,0,0,0,2'b00,3'b100,3'b000,1), 3'b000, "mul", accT);
    @(negedge clk);
    check("noM mul bundle", {16'h0, eBus2}, {16'h0, mkIll(3'b000)});
    check("noM mul illegalE", {31'h0, illegalE2}, 32'd1);
    check("noM mul regWriteE", {31'h0, regWriteE2}, 32'd0);
    check("mul no launch", startCnt - st0, 32'd0);
    idle(2);

    // Single divide: 1 start, 4 stall cycles, E advances on done cycle.
    st0 = startCnt;
    s0 = stallCnt;
    send(I_DIV, mk(1,0,0,0,0,2'b00,3'b100,3'b100,1), 3'b000, "div", accT);
    send(I_ADDI, mk(1,0,0,0,1,2'b10,3'b000,3'b000,0), 3'b000, "addi after div", accT);
    check("div advance cycles", int'((accT - startT) / 10), 32'd4);
    idle(3);
    check("div start count", startCnt - st0, 32'd1);
    check("div stall cycles", stallCnt - s0, 32'd4);

    // Back-to-back divides: second launches in its first E cycle.
    st0 = startCnt;
    s0 = stallCnt;
    send(I_DIV, mk(1,0,0,0,0,2'b00,3'b100,3'b100,1), 3'b000, "div b2b", accT);
    send(I_REM, mk(1,0,0,0,0,2'b00,3'b100,3'b110,1), 3'b000, "rem b2b", accT);
    send(I_ADDI, mk(1,0,0,0,1,2'b10,3'b000,3'b000,0), 3'b000, "addi b2b", accT);
    check("b2b rem advance cycles", int'((accT - startT) / 10), 32'd4);
    idle(3);
    check("b2b start count", startCnt - st0, 32'd2);
    check("b2b stall cycles", stallCnt - s0, 32'd8);

    // stallE held across mdu_done: E holds, no relaunch.
    st0 = startCnt;
    s0 = stallCnt;
    send(I_DIV, mk(1,0,0,0,0,2'b00,3'b100,3'b100,1), 3'b000, "div stallE", accT);
    stallE = 1'b1;
    instrD = I_ADDI;
    validD = 1'b1;
    repeat (8) @(posedge clk);
    #1;
    @(negedge clk);
    check("stallE hold divide in E", {30'h0, validE, mduE}, 32'd3);
    check("stallE no relaunch", startCnt - st0, 32'd1);
    check("stallE stall_mdu low", {31'h0, stall_mdu}, 32'd0);
    check("stallE stall cycles", stallCnt - s0, 32'd4);
    @(posedge clk);
    #1;
    stallE = 1'b0;
    send(I_ADDI, mk(1,0,0,0,1,2'b10,3'b000,3'b000,0), 3'b000, "addi after stallE", accT);
    idle(3);
    check("stallE final start count", startCnt - st0, 32'd1);

    // flushE while BUSY: kill pulse, bubble, stale done ignored.
    st0 = startCnt;
    s0 = stallCnt;
    k0 = killCnt;
    send(I_DIV, mk(1,0,0,0,0,2'b00,3'b100,3'b100,1), 3'b000, "div flush", accT);
    @(posedge clk);
    #1;
    flushE = 1'b1;
    @(negedge clk);
    check("flush mdu_kill", {31'h0, mdu_kill}, 32'd1);
    @(posedge clk);
    #1;
    flushE = 1'b0;
    @(negedge clk);
    check("flush validE", {31'h0, validE}, 32'd0);
    check("flush kill one cycle", {31'h0, mdu_kill}, 32'd0);
    repeat (5) @(posedge clk);
    #1;
    check("flush stale done start count", startCnt - st0, 32'd1);
    check("flush kill count", killCnt - k0, 32'd1);
    check("flush stall cycles", stallCnt - s0, 32'd2);
    check("flush E stays empty", {31'h0, validE}, 32'd0);
    send(I_ADDI, mk(1,0,0,0,1,2'b10,3'b000,3'b000,0), 3'b000, "addi after flush", accT);
    idle(2);

    // Async reset mid-BUSY, then a normal divide.
    send(I_DIV, mk(1,0,0,0,0,2'b00,3'b100,3'b100,1), 3'b000, "div reset", accT);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("reset mid-BUSY outputs", {10'h0, immSrcD, eBus, mdu_start, mdu_kill, stall_mdu}, 32'h0);
    expQ.delete();
    k0 = killCnt;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("no kill on reset", killCnt - k0, 32'd0);
    st0 = startCnt;
    s0 = stallCnt;
    send(I_DIV, mk(1,0,0,0,0,2'b00,3'b100,3'b100,1), 3'b000, "div post-reset", accT);
    send(I_ADDI, mk(1,0,0,0,1,2'b10,3'b000,3'b000,0), 3'b000, "addi post-reset", accT);
    check("post-reset advance cycles", int'((accT - startT) / 10), 32'd4);
    idle(3);
    check("post-reset start count", startCnt - st0, 32'd1);
    check("post-reset stall cycles", stallCnt - s0, 32'd4);

    check("scoreboard drained", expQ.size(), 32'd0);
    $display("[TB] %0d tests run, %0d failed", nTests, nFail);
    $finish;
  end

endmodule
